// File: rtl/ssp_rx.sv
`default_nettype none
// ============================================================================
// Module   : ssp_rx
// Brief    : SSP serial receiver. Oversamples sspclkin/sspfssin/ssprxd in the
//            clk_i domain, deserialises 8-bit frames into a show-ahead FIFO.
//            Build option SSP_RX_LSB_FIRST_EN assembles bytes LSB first.
// Revision : 1.0
// ============================================================================
module ssp_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sspclkin,
  input  logic       sspfssin,
  input  logic       ssprxd,
  input  logic       do_read,
  input  logic       clr_err,
  output logic [7:0] rx_d,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int                C_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam logic [C_ADDR_W:0] C_PTR_ONE = {{C_ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_fss_sync;
  logic [SYNC_STAGES-1:0] r_rxd_sync;
  logic                   r_clk_prev;
  logic                   w_sample;
  logic                   w_fss;
  logic                   w_rxd;

  state_t                 r_state;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic [7:0]             w_shift_next;
  logic                   r_done;
  logic [7:0]             r_byte;
  logic                   r_busy;
  logic                   r_frame_err;

  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [C_ADDR_W:0]      r_wr_ptr;
  logic [C_ADDR_W:0]      r_rd_ptr;
  logic                   r_overrun;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;

  // The clock chain resets high so a low sspclkin after reset is not a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk_sync <= '1;
      r_fss_sync <= '0;
      r_rxd_sync <= '0;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sspclkin};
      r_fss_sync <= {r_fss_sync[SYNC_STAGES-2:0], sspfssin};
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], ssprxd};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sample = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_fss    = r_fss_sync[SYNC_STAGES-1];
  assign w_rxd    = r_rxd_sync[SYNC_STAGES-1];

`ifdef SSP_RX_LSB_FIRST_EN
  assign w_shift_next = {w_rxd, r_shift[7:1]};
`else
  assign w_shift_next = {r_shift[6:0], w_rxd};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= 8'h00;
      r_done      <= 1'b0;
      r_byte      <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_sample) begin
        case (r_state)
          IDLE: begin
            if (w_fss) begin
              r_state <= RECV;
              r_busy  <= 1'b1;
              r_cnt   <= 3'd7;
              r_shift <= 8'h00;
            end
          end
          RECV: begin
            if (r_cnt == 3'd0) begin
              r_done  <= 1'b1;
              r_byte  <= w_shift_next;
              r_shift <= 8'h00;
              r_cnt   <= 3'd7;
              // A sync on the bit-0 sample chains straight into the next frame.
              if (!w_fss) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else if (w_fss) begin
              r_frame_err <= 1'b1;
              r_shift     <= 8'h00;
              r_cnt       <= 3'd7;
            end else begin
              r_shift <= w_shift_next;
              r_cnt   <= r_cnt - 3'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                   (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);
  assign w_pop   = do_read & ~w_empty;
  // A same-cycle pop frees the slot, so a full FIFO can still accept the byte.
  assign w_push  = r_done & (~w_full | w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[C_ADDR_W-1:0]] <= r_byte;
        r_wr_ptr                      <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (clr_err) begin
        r_overrun <= 1'b0;
      end
      if (r_done && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign rx_d         = r_mem[r_rd_ptr[C_ADDR_W-1:0]];
  assign rx_empty     = w_empty;
  assign rx_full      = w_full;
  assign rx_busy      = r_busy;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssp_rx
// Brief    : Directed self-checking bench for ssp_rx (sspclkin = clk_i/8).
// Revision : 1.0
// ============================================================================
module tb_ssp_rx;

  logic       clk_i    = 1'b0;
  logic       rst_i    = 1'b0;
  logic       sspclkin = 1'b0;
  logic       sspfssin = 1'b0;
  logic       ssprxd   = 1'b0;
  logic       do_read  = 1'b0;
  logic       clr_err  = 1'b0;
  logic [7:0] rx_d;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_busy;
  logic       rx_overrun;
  logic       rx_frame_err;

  int checks = 0;
  int errors = 0;

  ssp_rx #(
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sspclkin    (sspclkin),
    .sspfssin    (sspfssin),
    .ssprxd      (ssprxd),
    .do_read     (do_read),
    .clr_err     (clr_err),
    .rx_d        (rx_d),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .rx_busy     (rx_busy),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  always #5 clk_i = ~clk_i;

  // Byte the receiver should present for a frame transmitted MSB first as b.
  function automatic logic [7:0] exp8(input logic [7:0] b);
    logic [7:0] r;
`ifdef SSP_RX_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic send_bit(input logic f, input logic d);
    sspclkin = 1'b1; sspfssin = f; ssprxd = d;
    repeat (4) @(negedge clk_i);
    sspclkin = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic sync_pulse();
    send_bit(1'b1, 1'b0);
  endtask

  // mode 0: plain, 1: check rx_empty latency, 2: assert do_read on the push cycle
  task automatic send_frame(input logic [7:0] b, input logic sync_last, input int mode);
    for (int i = 7; i >= 1; i--) send_bit(1'b0, b[i]);
    sspclkin = 1'b1; sspfssin = sync_last; ssprxd = b[0];
    repeat (4) @(negedge clk_i);
    sspclkin = 1'b0;
    if (mode == 1) begin
      repeat (3) @(posedge clk_i); #1;
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL lat_empty_hold: rx_empty=%b want 1", rx_empty); end
      @(posedge clk_i); #1;
      checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL lat_empty_fall: rx_empty=%b want 0", rx_empty); end
      @(negedge clk_i);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk_i);
      do_read = 1'b1;
      @(negedge clk_i);
      do_read = 1'b0;
    end else begin
      repeat (4) @(negedge clk_i);
    end
    sspfssin = 1'b0;
  endtask

  task automatic pop();
    do_read = 1'b1;
    @(negedge clk_i);
    do_read = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_i);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", rx_empty); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", rx_full); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", rx_busy); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", rx_overrun); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", rx_frame_err); end
    checks++; if (rx_d !== 8'h00) begin errors++; $display("FAIL rst_rx_d: got %h want 00", rx_d); end
    rst_i = 1'b0;
    repeat (3) send_bit(1'b0, 1'b1);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL idle_empty: got %b want 1", rx_empty); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_single();
    sync_pulse();
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", rx_busy); end
    send_frame(8'hA5, 1'b0, 1);
    checks++; if (rx_d !== exp8(8'hA5)) begin errors++; $display("FAIL single_a5: got %h want %h", rx_d, exp8(8'hA5)); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", rx_busy); end
    pop();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b want 1", rx_empty); end
    sync_pulse();
    send_frame(8'h01, 1'b0, 0);
    checks++; if (rx_d !== exp8(8'h01)) begin errors++; $display("FAIL single_01: got %h want %h", rx_d, exp8(8'h01)); end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    sync_pulse();
    for (int i = 0; i < 4; i++) send_frame(vals[i], (i < 3), 0);
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b want 1", rx_full); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b want 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", rx_overrun); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_d !== exp8(vals[i])) begin errors++; $display("FAIL b2b_read%0d: got %h want %h", i, rx_d, exp8(vals[i])); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", rx_empty); end
  endtask

  task automatic test_overrun();
    logic [7:0] vals [4];
    logic [7:0] after [4];
    vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
    after = '{8'h22, 8'h33, 8'h44, 8'h66};
    sync_pulse();
    for (int i = 0; i < 4; i++) send_frame(vals[i], 1'b1, 0);
    send_frame(8'h55, 1'b0, 0);
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", rx_overrun); end
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b want 1", rx_full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_d !== exp8(vals[i])) begin errors++; $display("FAIL ovr_read%0d: got %h want %h", i, rx_d, exp8(vals[i])); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_empty: got %b want 1", rx_empty); end
    pulse_clr();
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
    sync_pulse();
    for (int i = 0; i < 4; i++) send_frame(vals[i], 1'b1, 0);
    send_frame(8'h66, 1'b0, 2);
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_rdpush_flag: got %b want 0", rx_overrun); end
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_rdpush_full: got %b want 1", rx_full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_d !== exp8(after[i])) begin errors++; $display("FAIL ovr_rdpush_read%0d: got %h want %h", i, rx_d, exp8(after[i])); end
      pop();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_rdpush_empty: got %b want 1", rx_empty); end
  endtask

  task automatic test_frame_err();
    sync_pulse();
    repeat (3) send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", rx_frame_err); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ferr_no_push: got %b want 1", rx_empty); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy: got %b want 1", rx_busy); end
    send_frame(8'h3C, 1'b0, 0);
    checks++; if (rx_d !== exp8(8'h3C)) begin errors++; $display("FAIL ferr_3c: got %h want %h", rx_d, exp8(8'h3C)); end
    pop();
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ferr_one_entry: got %b want 1", rx_empty); end
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", rx_frame_err); end
    pulse_clr();
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b want 0", rx_frame_err); end
  endtask

  task automatic test_reset_mid();
    sync_pulse();
    send_frame(8'h5A, 1'b0, 0);
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL rmid_pre_empty: got %b want 0", rx_empty); end
    sync_pulse();
    repeat (5) send_bit(1'b0, 1'b1);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rmid_pre_busy: got %b want 1", rx_busy); end
    sspclkin = 1'b1; ssprxd = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", rx_empty); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", rx_busy); end
    checks++; if (rx_d !== 8'h00) begin errors++; $display("FAIL rmid_rx_d: got %h want 00", rx_d); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b want 0", rx_full); end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    sspclkin = 1'b0;
    repeat (4) @(negedge clk_i);
    send_frame(8'h7E, 1'b0, 0);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rmid_nosync: got %b want 1", rx_empty); end
    sync_pulse();
    send_frame(8'h7E, 1'b0, 0);
    checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL rmid_rx_empty: got %b want 0", rx_empty); end
    checks++; if (rx_d !== exp8(8'h7E)) begin errors++; $display("FAIL rmid_7e: got %h want %h", rx_d, exp8(8'h7E)); end
    pop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ssp_rx.md
Name: ssp_rx

Overview:
- Receive-side companion of the SSP transmit path.
- Oversamples an external SSP serial link (sspclkin, sspfssin, ssprxd) in the system clock domain.
- Deserialises 8-bit frames, MSB first by default, into a small FIFO that the host drains with a read strobe.
- Flags overrun and framing errors as sticky status bits.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on each serial input; minimum 2.

Ports:
- clk_i  input  1  system clock; must run at least 4x sspclkin.
- rst_i  input  1  asynchronous, active-high reset.
- sspclkin  input  1  serial bit clock, asynchronous to clk_i.
- sspfssin  input  1  frame sync, driven on sspclkin rising edge.
- ssprxd  input  1  serial data, driven on sspclkin rising edge.
- do_read  input  1  pop strobe; ignored when rx_empty=1.
- clr_err  input  1  clears rx_overrun and rx_frame_err.
- rx_d  output  8  FIFO head (show-ahead); valid while rx_empty=0.
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO full.
- rx_busy  output  1  frame reception in progress.
- rx_overrun  output  1  sticky: completed frame dropped because FIFO was full.
- rx_frame_err  output  1  sticky: sync seen mid-frame.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high; all state is cleared immediately on assertion.
- Reset values: rx_d=0, rx_empty=1, rx_full=0, rx_busy=0, rx_overrun=0, rx_frame_err=0. Bit counter=0, FIFO pointers=0, synchroniser flops=0 except the sspclkin chain, which resets to 1 so no false edge is seen.
- Synchronisation: sspclkin, sspfssin and ssprxd each pass through SYNC_STAGES flops of identical depth, which preserves their relative alignment.
- Sample event S: a one-clk_i strobe asserted when the synchronised sspclkin is 1 in the previous cycle and 0 in the current one (falling edge). All serial sampling happens only on S.
- FSM states: IDLE, RECV.
  - IDLE: on S with fss=1 -> RECV, bit counter=7. On S with fss=0, or no S -> remain in IDLE.
  - RECV: on each S, shift the data bit into the shift register (MSB first), then decrement the counter. rx_busy=1 while in RECV.
  - RECV, S with counter=0: this is the bit-0 sample. Raise the frame-complete strobe. If fss=1 on this same S, the next frame starts back-to-back: stay in RECV with counter=7, giving an 8-bit-clock minimum frame period. Otherwise go to IDLE.
  - RECV, S with fss=1 and counter in 7..1: set rx_frame_err, discard the partial byte, restart with counter=7.
- Frame-complete handling: the byte is pushed into the FIFO on the clk_i edge after the bit-0 S. rx_empty falls 1 cycle after that push, i.e. 2 clk_i cycles after the bit-0 S.
- Push onto a full FIFO: byte dropped, rx_overrun set, FIFO contents unchanged.
- Push and do_read in the same cycle on a full FIFO: the pop is applied first, the push succeeds, rx_overrun stays 0, rx_full stays 1.
- do_read while empty: no effect. Pointers do not wrap into an underflow state.
- Pointers: log2(FIFO_DEPTH)+1 bits each, with natural wrap. Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
- clr_err with a same-cycle error event: the set wins, so the flag stays 1.
- Reset mid-frame: the partial byte is lost, the FIFO is emptied, the FSM returns to IDLE, and the first frame after release needs a fresh sync.

Optional Feature:
- Macro: SSP_RX_LSB_FIRST_EN.
- Defined: bits are assembled LSB first; the first sample after sync becomes rx_d[0].
- Undefined: MSB first; the first sample after sync becomes rx_d[7]. This matches the default transmit order.
- Framing, FIFO and flag behaviour are identical in both builds.

Test Plan:
- Reset then idle: with rst_i held 1, rx_empty=1, rx_busy=0 and both flags=0; after release, sspclkin toggling with fss=0 leaves rx_empty=1.
- Single frame 0xA5: sync pulse, then 8 bits at sspclkin=clk_i/8. rx_empty falls 2 clk_i after the bit-0 S, and rx_d=0xA5. With SSP_RX_LSB_FIRST_EN defined, the same bit stream reads back 0xA5 bit-reversed, i.e. 0xA5 (palindrome); also check 0x01 read back as 0x80.
- Back-to-back: sync on each bit-0 edge, frames 0x11, 0x22, 0x33, 0x44. rx_full=1, and four reads return them in order; rx_frame_err=0.
- Overrun: FIFO full with 0x11-0x44, fifth frame 0x55. rx_overrun=1, reads still return 0x11-0x44. clr_err -> rx_overrun=0. Then a full FIFO with a read on the push cycle gives no overrun.
- Framing error: sync reasserted at the 4th bit. rx_frame_err=1, the partial byte is never pushed, and the following 8 bits 0x3C are received as 0x3C.
- Async reset mid-frame: assert rst_i after 5 bits. Outputs return to reset values immediately, and the next complete frame 0x7E is received correctly.
